// File: rtl/fptd_pkg.sv
// Shared types and helpers for the fully parallel turbo decoder stages.
// Holds the FSM state type, default widths and the saturating clip helper.
package fptd_pkg;

    localparam int N_DEF         = 5;
    localparam int M_DEF         = 6;
    localparam int RAZOR_BIT_DEF = 1;

    typedef enum logic {
        CHECK   = 1'b0,
        RECOVER = 1'b1
    } state_t;

    // Clip a signed value into the range of an (m+1)-bit signed number.
    function automatic int BitClip(input int value, input int m);
        int hi;
        int lo;
        hi = (1 << m) - 1;
        lo = -(1 << m);
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/razor_shadow.sv
// Razor shadow register: captures the guarded bits on a sample strobe and
// flags when the freshly settled bits disagree with the main registers.
module razor_shadow #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample,
    input  logic         clear,
    input  logic [W-1:0] din,
    input  logic [W-1:0] ref_bits,
    output logic [W-1:0] shadow,
    output logic         valid,
    output logic         mismatch
);

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            valid  <= 1'b0;
        end else if (sample) begin
            shadow <= din;
            valid  <= 1'b1;
        end else if (clear) begin
            valid  <= 1'b0;
        end
    end

    // The compare uses the late-settled value so the error is known on the sampling edge itself.
    assign mismatch = (din != ref_bits);

endmodule

// File: rtl/be1_razor1.sv
// Branch-metric stage feeding alpha/beta recursion, with razor-style detection
// of late-settling guarded bits and a reload-based recovery FSM.
module be1_razor1
    import fptd_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int M        = M_DEF,
    parameter int RazorBit = RAZOR_BIT_DEF,
    parameter int ErrCntW  = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 Error_previous_Alpha,
    input  logic signed [N-1:0]  La1,
    input  logic signed [N-1:0]  Lc2,
    input  logic signed [N-1:0]  Lc3,
    output logic signed [N-1:0]  ba2,
    output logic signed [M:0]    ba1ba3,
    output logic signed [M:0]    ba1ba2ba3,
    output logic                 Error_current_be1,
    output logic [ErrCntW-1:0]   ErrCount
);

    state_t state;
    state_t state_next;

    logic signed [N+1:0] sum13;
    logic signed [N+1:0] sum123;
    int                  clip13;
    int                  clip123;
    logic signed [N-1:0] ba2_d;
    logic signed [M:0]   ba1ba3_d;
    logic signed [M:0]   ba1ba2ba3_d;
    logic [2:0]          guard_d;
    logic [2:0]          guard_q;

    logic       load;
    logic       sample;
    logic       raise;
    logic       captured;
    logic       mismatch;
    logic [2:0] shadow_bits;
    logic       shadow_valid;

    // Sums are widened by two bits so even three full-scale operands cannot wrap before clipping.
    always_comb begin
        sum13       = {{2{La1[N-1]}}, La1} + {{2{Lc3[N-1]}}, Lc3};
        sum123      = sum13 + {{2{Lc2[N-1]}}, Lc2};
        clip13      = BitClip(int'(sum13), M);
        clip123     = BitClip(int'(sum123), M);
        ba2_d       = Lc2;
        ba1ba3_d    = clip13[M:0];
        ba1ba2ba3_d = clip123[M:0];
    end

    assign guard_d = {ba2_d[N-RazorBit], ba1ba3_d[M+1-RazorBit], ba1ba2ba3_d[M+1-RazorBit]};
    assign guard_q = {ba2[N-RazorBit],   ba1ba3[M+1-RazorBit],   ba1ba2ba3[M+1-RazorBit]};

    razor_shadow #(.W(3)) u_shadow (
        .clk      (Clock),
        .reset    (Reset),
        .sample   (sample),
        .clear    (load),
        .din      (guard_d),
        .ref_bits (guard_q),
        .shadow   (shadow_bits),
        .valid    (shadow_valid),
        .mismatch (mismatch)
    );

    // Shadow contents are kept for observability; only the live compare steers control.
    logic unused_shadow;
    assign unused_shadow = ^{shadow_bits, shadow_valid};

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= CHECK;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        sample     = 1'b0;
        raise      = 1'b0;
        case (state)
            CHECK: begin
                if (!Error_previous_Alpha) begin
                    if (Enable) begin
                        load = 1'b1;
                    end else begin
                        sample = 1'b1;
                        if (mismatch && captured) begin
                            raise      = 1'b1;
                            state_next = RECOVER;
                        end
                    end
                end
            end
            RECOVER: begin
                // Recovery must complete even while the downstream stage is stalled.
                if (Enable) begin
                    load       = 1'b1;
                    state_next = CHECK;
                end
            end
            default: state_next = CHECK;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ba2               <= '0;
            ba1ba3            <= '0;
            ba1ba2ba3         <= '0;
            captured          <= 1'b0;
            Error_current_be1 <= 1'b0;
            ErrCount          <= '0;
        end else begin
            if (load) begin
                ba2       <= ba2_d;
                ba1ba3    <= ba1ba3_d;
                ba1ba2ba3 <= ba1ba2ba3_d;
                captured  <= 1'b1;
            end
            Error_current_be1 <= (state_next == RECOVER);
            if (raise && (ErrCount != '1))
                ErrCount <= ErrCount + 1'b1;
        end
    end

endmodule
